// File: rtl/dab_pkg.sv
// Shared types and limits for the DAB setpoint sequencer.
// Angles are 9-bit; slew arithmetic is widened to 10-bit signed.
package dab_pkg;

  localparam int ANGLE_W   = 9;
  localparam int DIFF_W    = 10;
  localparam int FS_W      = 19;
  localparam int ANGLE_MAX = 255;
  localparam int ANGLE_MIN = -255;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  function automatic logic [ANGLE_W-1:0] clamp_u(
    input logic [ANGLE_W-1:0] v
  );
    if (v > ANGLE_W'(ANGLE_MAX))
      return ANGLE_W'(ANGLE_MAX);
    return v;
  endfunction

  // Only -256 lies outside the symmetric range.
  function automatic logic signed [ANGLE_W-1:0] clamp_s(
    input logic signed [ANGLE_W-1:0] v
  );
    if (v < ANGLE_W'(ANGLE_MIN))
      return ANGLE_W'(ANGLE_MIN);
    return v;
  endfunction

endpackage

// File: rtl/dab_param_sequencer_slew_step.sv
// One slew-limited step of a value toward its target.
// All operands fit 10-bit signed without wrapping.
module slew_step
  import dab_pkg::*;
(
  input  logic signed [DIFF_W-1:0] cur,
  input  logic signed [DIFF_W-1:0] tgt,
  input  logic signed [DIFF_W-1:0] step,
  output logic signed [DIFF_W-1:0] nxt
);

  logic signed [DIFF_W-1:0] diff;
  logic signed [DIFF_W-1:0] nstep;

  always_comb begin
    diff  = tgt - cur;
    nstep = -step;
    nxt   = tgt;
    unique case (1'b1)
      (diff > step):  nxt = cur + step;
      (diff < nstep): nxt = cur - step;
      default:        nxt = tgt;
    endcase
  end

endmodule

// File: rtl/dab_param_sequencer.sv
// Host setpoint sequencer for the DAB modulator: applies t1/t2/phi
// slew-limited once per switching period, fs_DAB on the first update.
module dab_param_sequencer
  import dab_pkg::*;
#(
  parameter int T_STEP   = 32,
  parameter int PHI_STEP = 16,
  parameter int FS_RESET = 100000,
  parameter int FS_MIN   = 10000,
  parameter int FS_MAX   = 250000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ANGLE_W-1:0]        req_t1,
  input  logic [ANGLE_W-1:0]        req_t2,
  input  logic signed [ANGLE_W-1:0] req_phi,
  input  logic [FS_W-1:0]           req_fs,
  input  logic                      period_start,
  input  logic                      hold,
  output logic [ANGLE_W-1:0]        t1,
  output logic [ANGLE_W-1:0]        t2,
  output logic signed [ANGLE_W-1:0] phi,
  output logic [FS_W-1:0]           fs_DAB,
  output logic                      sync,
  output logic                      busy,
  output logic                      done
);

  localparam logic signed [DIFF_W-1:0] TS = DIFF_W'(T_STEP);
  localparam logic signed [DIFF_W-1:0] PS = DIFF_W'(PHI_STEP);
  localparam logic [FS_W-1:0] FS_RST = FS_W'(FS_RESET);
  localparam logic [FS_W-1:0] FS_LO  = FS_W'(FS_MIN);
  localparam logic [FS_W-1:0] FS_HI  = FS_W'(FS_MAX);

  state_t state, state_nxt;

  logic [ANGLE_W-1:0]        t1_tgt;
  logic [ANGLE_W-1:0]        t2_tgt;
  logic signed [ANGLE_W-1:0] phi_tgt;
  logic [FS_W-1:0]           fs_tgt;
  logic                      first;

  logic [FS_W-1:0] fs_clamped;
  logic accept;
  logic upd;
  logic at_tgt;

  logic signed [DIFF_W-1:0] n1, n2, nphi;

  slew_step u_t1 (
    .cur  ({1'b0, t1}),
    .tgt  ({1'b0, t1_tgt}),
    .step (TS),
    .nxt  (n1)
  );

  slew_step u_t2 (
    .cur  ({1'b0, t2}),
    .tgt  ({1'b0, t2_tgt}),
    .step (TS),
    .nxt  (n2)
  );

  slew_step u_phi (
    .cur  ({phi[ANGLE_W-1], phi}),
    .tgt  ({phi_tgt[ANGLE_W-1], phi_tgt}),
    .step (PS),
    .nxt  (nphi)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state == RAMP);
  assign accept    = req_valid && req_ready;
  assign upd       = busy && period_start && !hold;

  // fs always matches its target after the first update.
  assign at_tgt = (n1 == {1'b0, t1_tgt})
               && (n2 == {1'b0, t2_tgt})
               && (nphi == {phi_tgt[ANGLE_W-1], phi_tgt});

  always_comb begin
    fs_clamped = req_fs;
    if (req_fs < FS_LO)
      fs_clamped = FS_LO;
    else if (req_fs > FS_HI)
      fs_clamped = FS_HI;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = RAMP;
      RAMP: if (upd && at_tgt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1      <= '0;
      t2      <= '0;
      phi     <= '0;
      fs_DAB  <= FS_RST;
      sync    <= 1'b0;
      done    <= 1'b0;
      t1_tgt  <= '0;
      t2_tgt  <= '0;
      phi_tgt <= '0;
      fs_tgt  <= FS_RST;
      first   <= 1'b0;
    end else begin
      sync <= 1'b0;
      done <= 1'b0;
      if (accept) begin
        t1_tgt  <= clamp_u(req_t1);
        t2_tgt  <= clamp_u(req_t2);
        phi_tgt <= clamp_s(req_phi);
        fs_tgt  <= fs_clamped;
        first   <= 1'b1;
      end
      if (upd) begin
        t1    <= n1[ANGLE_W-1:0];
        t2    <= n2[ANGLE_W-1:0];
        phi   <= nphi[ANGLE_W-1:0];
        first <= 1'b0;
        done  <= at_tgt;
        if (first) begin
          fs_DAB <= fs_tgt;
          sync   <= (fs_tgt != fs_DAB);
        end
      end
    end
  end

endmodule

// File: tb/tb_dab_param_sequencer.sv
// Directed self-checking bench for dab_param_sequencer.
module tb_dab_param_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [8:0]        req_t1;
  logic [8:0]        req_t2;
  logic signed [8:0] req_phi;
  logic [18:0]       req_fs;
  logic              period_start;
  logic              hold;
  logic [8:0]        t1;
  logic [8:0]        t2;
  logic signed [8:0] phi;
  logic [18:0]       fs_DAB;
  logic              sync;
  logic              busy;
  logic              done;

  int n_chk = 0;
  int n_fail = 0;

  dab_param_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_t1       (req_t1),
    .req_t2       (req_t2),
    .req_phi      (req_phi),
    .req_fs       (req_fs),
    .period_start (period_start),
    .hold         (hold),
    .t1           (t1),
    .t2           (t2),
    .phi          (phi),
    .fs_DAB       (fs_DAB),
    .sync         (sync),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int a, input int b,
                         input int p, input int f);
    req_t1  = 9'(a);
    req_t2  = 9'(b);
    req_phi = 9'(p);
    req_fs  = 19'(f);
  endtask

  task automatic request(input int a, input int b,
                         input int p, input int f);
    set_req(a, b, p, f);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic pulse();
    period_start = 1'b1;
    step();
    period_start = 1'b0;
  endtask

  initial begin
    int e1, e2, ep;
    rst_n = 1'b0;
    req_valid = 1'b0;
    period_start = 1'b0;
    hold = 1'b0;
    set_req(0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_t1", t1, 0);
    chk("rst_t2", t2, 0);
    chk("rst_phi", phi, 0);
    chk("rst_fs", fs_DAB, 100000);
    chk("rst_ready", req_ready, 1);
    chk("rst_sync", sync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // basic ramp
    request(223, 128, -32, 100000);
    chk("acc_busy", busy, 1);
    chk("acc_ready", req_ready, 0);
    step();
    chk("idle_gap_t1", t1, 0);
    for (int k = 1; k <= 7; k++) begin
      e1 = (32 * k > 223) ? 223 : 32 * k;
      e2 = (32 * k > 128) ? 128 : 32 * k;
      ep = (-16 * k < -32) ? -32 : -16 * k;
      pulse();
      chk("ramp_t1", t1, e1);
      chk("ramp_t2", t2, e2);
      chk("ramp_phi", phi, ep);
      chk("ramp_sync", sync, 0);
      chk("ramp_done", done, (k == 7) ? 1 : 0);
      step();
      chk("ramp_hold_t1", t1, e1);
    end
    chk("ramp_end_ready", req_ready, 1);
    chk("ramp_end_done", done, 0);

    // frequency change with identical angles
    request(223, 128, -32, 50000);
    step();
    pulse();
    chk("fs_val", fs_DAB, 50000);
    chk("fs_sync", sync, 1);
    chk("fs_done", done, 1);
    chk("fs_t1", t1, 223);
    step();
    chk("fs_sync_clr", sync, 0);
    chk("fs_idle", busy, 0);

    // clamp request colliding with period_start
    set_req(300, 128, -256, 5000);
    req_valid = 1'b1;
    period_start = 1'b1;
    step();
    req_valid = 1'b0;
    period_start = 1'b0;
    chk("coll_t1", t1, 223);
    chk("coll_phi", phi, -32);
    chk("coll_fs", fs_DAB, 50000);
    chk("coll_busy", busy, 1);
    chk("coll_sync", sync, 0);
    pulse();
    chk("clamp_t1", t1, 255);
    chk("clamp_phi1", phi, -48);
    chk("clamp_fs", fs_DAB, 10000);
    chk("clamp_sync", sync, 1);
    ep = -48;

    hold = 1'b1;
    repeat (3) begin
      pulse();
      chk("hold_phi", phi, -48);
      chk("hold_sync", sync, 0);
      chk("hold_done", done, 0);
    end
    hold = 1'b0;

    // host request during RAMP must be ignored
    set_req(0, 0, 0, 200000);
    req_valid = 1'b1;
    pulse();
    req_valid = 1'b0;
    ep = -64;
    chk("busyreq_phi", phi, ep);
    chk("busyreq_sync", sync, 0);
    for (int i = 0; i < 20; i++) begin
      pulse();
      ep = (ep - 16 < -255) ? -255 : ep - 16;
      chk("clamp_phi", phi, ep);
      chk("clamp_t1_keep", t1, 255);
      chk("clamp_ramp_done", done, (ep == -255) ? 1 : 0);
      if (ep == -255) break;
    end
    chk("clamp_fs_end", fs_DAB, 10000);
    step();
    chk("clamp_ready", req_ready, 1);
    chk("clamp_fs_keep", fs_DAB, 10000);

    // reset mid-ramp
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    request(200, 0, 0, 100000);
    repeat (3) pulse();
    chk("mid_t1", t1, 96);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_t1", t1, 0);
    chk("mr_fs", fs_DAB, 100000);
    chk("mr_busy", busy, 0);
    chk("mr_ready", req_ready, 1);
    pulse();
    chk("mr_nopulse_t1", t1, 0);
    request(32, 0, 0, 100000);
    chk("mr_acc_busy", busy, 1);
    pulse();
    chk("mr_t1_new", t1, 32);
    chk("mr_done_new", done, 1);
    chk("mr_sync_new", sync, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dab_param_sequencer.md
# dab_param_sequencer

Setpoint sequencer for the DAB modulator: accepts a new operating point (t1, t2, phi, fs_DAB) from the host via a valid/ready handshake. It applies the point to the modulator only at switching-period boundaries, slew-limiting t1, t2 and phi per period so that transformer volt-second balance is never disturbed. It sits between the host/control loop and `top`'s modulation inputs, and emits the modulator `sync` pulse whenever the switching frequency changes.

## Interface
- `T_STEP`, 32: max |Δt1|, |Δt2| applied per switching period (1..255)
- `PHI_STEP`, 16: max |Δphi| applied per switching period (1..255)
- `FS_RESET`, 100000: fs_DAB reset value, Hz
- `FS_MIN`, 10000 / `FS_MAX`, 250000: fs_DAB clamp limits, Hz
- `clk` in 1: system clock, 100 MHz
- `rst_n` in 1: synchronous, active-low reset (one clock; reset is synchronous and active-low)
- `req_valid` in 1: host setpoint valid
- `req_ready` out 1: sequencer can accept a setpoint
- `req_t1`, `req_t2` in 9: unsigned targets, 0..255 ↔ 0..π
- `req_phi` in 9: two's-complement target, −255..255 ↔ −π..π
- `req_fs` in 19: target switching frequency, Hz
- `period_start` in 1: one-cycle pulse from modulator at the start of each switching period
- `hold` in 1: freeze ramp (period_start ignored while high)
- `t1`, `t2` out 9: applied values to modulator
- `phi` out 9: applied value, signed
- `fs_DAB` out 19: applied frequency
- `sync` out 1: one-cycle modulator resync pulse
- `busy` out 1: ramp in progress
- `done` out 1: one-cycle pulse when target reached

## Operation
- States: IDLE, RAMP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, clamped targets are latched into shadow registers → RAMP. Clamping: t1, t2 >255 → 255; phi −256 → −255; fs to [FS_MIN, FS_MAX].
- RAMP: `req_ready`=0, `busy`=1. On each `period_start` with `hold`=0, one update is applied:
  - t1, t2 move toward target by min(|diff|, T_STEP).
  - phi moves by min(|diff|, PHI_STEP).
  - fs_DAB jumps to target (first update only); if the value changes, `sync`=1 for that cycle.
- Differences are computed in 10-bit signed; no wrap permitted.
- If all four applied values equal their targets after an update: `done`=1, → IDLE.
- Request equal to current outputs: still enters RAMP; completes on the first period_start with `done`, no `sync`.
- Updates never occur outside RAMP; applied values hold indefinitely in IDLE.

## Timing
- Reset values: t1=0, t2=0, phi=0, fs_DAB=FS_RESET, sync=0, busy=0, done=0, state IDLE. `req_ready`=1 in the first cycle after reset release.
- `req_ready` and `busy` are decoded from state. All other outputs are registered.
- Handshake edge N → RAMP at N+1. period_start sampled at edge M>N → new values, `sync`, and `done` all visible after edge M, together in the same cycle.
- `req_valid` and `period_start` in the same IDLE cycle: request accepted, period_start ignored. First update occurs at the next period_start.
- `req_valid` while RAMP: ignored (not latched); host must hold it until ready.
- `hold` and `period_start` high together: no update, no sync.
- `rst_n` low mid-ramp: targets discarded, outputs return to reset values at the next edge, state IDLE.
- Worst-case ramp: ceil(255/T_STEP) or ceil(510/PHI_STEP) periods, whichever is greater.

## Structure
- Shared package `dab_pkg`: state encoding, widths (ANGLE_W=9, FS_W=19), angle limits (255, −255).
- One sub-module, `slew_step`: given current, target and step (10-bit signed), returns the next value. It is instantiated 3×: t1, t2, phi.

## Test plan
- Reset: assert rst_n=0 for 3 cycles → t1=t2=phi=0, fs_DAB=100000, req_ready=1, sync=busy=done=0.
- Ramp: request t1=223, t2=128, phi=−32, fs=100000, with periodic period_start → per-period t1 = 32, 64, …, 192, 223. t2 reaches 128 after 4 updates; phi goes −16, −32. `done` coincides with the 7th update; no sync.
- Frequency change: from steady state, request fs=50000 with identical angles → fs_DAB=50000 at first period_start, with sync=1 and done=1 in that same cycle.
- Clamp: request t1=300, phi=−256, fs=5000 → final t1=255, phi=−255, fs_DAB=10000.
- Collision and hold: req_valid together with period_start → no update that cycle. With hold=1 across 3 period_starts → outputs frozen; ramp resumes after hold=0.
- Reset mid-ramp: during the t1 ramp (t1=96), pulse rst_n=0 → reset values next edge. A new request is then accepted normally.
